// File: rtl/bp_initiator_pkg.sv
// ---------------------------------------------------------------------------
// bp_initiator_pkg
// Shared types for the bus initiator. Contents:
//   - BP_* default widths
//   - state_t:  transaction FSM states
//   - bp_req_t: one queued bus request, as stored in the request FIFO
// The struct is sized by the package defaults. The top module casts its
// parameterised ports into and out of these fields.
// ---------------------------------------------------------------------------
package bp_initiator_pkg;

  localparam int BP_ADDR_WIDTH = 32;
  localparam int BP_DATA_WIDTH = 32;
  localparam int BP_STRB_WIDTH = BP_DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef struct packed {
    logic                     write;
    logic [BP_ADDR_WIDTH-1:0] addr;
    logic [BP_DATA_WIDTH-1:0] wdata;
    logic [BP_STRB_WIDTH-1:0] strobe;
  } bp_req_t;

endpackage

// File: rtl/bp_initiator_if.sv
// ---------------------------------------------------------------------------
// bus_protocol_if
// Simple memory-mapped peripheral bus.
//   Master -> peripheral: wen, ren, addr, wdata, strobe, plus the hint
//     fields is_burst, burst_type, burst_length and secure_transfer.
//   Peripheral -> master: rdata, error, request_stall.
// Modports:
//   protocol   - master side (bus initiator)
//   peripheral - slave side
// ---------------------------------------------------------------------------
interface bus_protocol_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  logic                    wen;
  logic                    ren;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] strobe;

  logic                    is_burst;
  logic [1:0]              burst_type;
  logic [7:0]              burst_length;
  logic                    secure_transfer;

  logic [DATA_WIDTH-1:0]   rdata;
  logic                    error;
  logic                    request_stall;

  modport protocol (
    output wen, ren, addr, wdata, strobe,
    output is_burst, burst_type, burst_length, secure_transfer,
    input  rdata, error, request_stall
  );

  modport peripheral (
    input  wen, ren, addr, wdata, strobe,
    input  is_burst, burst_type, burst_length, secure_transfer,
    output rdata, error, request_stall
  );

endinterface

// File: rtl/bp_initiator_fifo.sv
// ---------------------------------------------------------------------------
// bp_req_fifo
// Synchronous request FIFO of bp_req_t entries. The head entry is shown
// combinationally on rdata.
// Ports:
//   clk, nReset  - clock; synchronous active-high reset (clears pointers)
//   push, wdata  - enqueue; ignored when full
//   pop          - dequeue head; ignored when empty
//   rdata        - current head entry
//   full, empty  - derived from the registered occupancy count
// ---------------------------------------------------------------------------
module bp_req_fifo
  import bp_initiator_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    nReset,
  input  logic    push,
  input  logic    pop,
  input  bp_req_t wdata,
  output bp_req_t rdata,
  output logic    full,
  output logic    empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  bp_req_t         mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            push_ok;
  logic            pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Pointers wrap naturally because DEPTH is a power of two.
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (nReset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; validity is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/bp_initiator.sv
// ---------------------------------------------------------------------------
// bp_initiator
// Bus master for bus_protocol_if. A local requester queues read and write
// commands through a request FIFO. The block issues them one at a time,
// honours request_stall, and aborts after STALL_TIMEOUT consecutive stalls.
// Each result is returned through a registered response port.
// Ports:
//   clk, nReset        - clock; synchronous active-high reset
//   req_valid/ready    - request handshake (ready = FIFO not full)
//   req_write, req_addr, req_wdata, req_strobe - request payload
//   rsp_valid/ready    - response handshake
//   rsp_rdata, rsp_error, rsp_timeout - response payload
//   bp                 - bus_protocol_if.protocol master port
// ---------------------------------------------------------------------------
module bp_initiator
  import bp_initiator_pkg::*;
#(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int FIFO_DEPTH    = 4,
  parameter int STALL_TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    nReset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_strobe,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_error,
  output logic                    rsp_timeout,
  bus_protocol_if.protocol        bp
);

  localparam int CNT_W = $clog2(STALL_TIMEOUT + 1);
  // Counter value at which one more stalled edge reaches the timeout.
  localparam logic [CNT_W-1:0] STALL_LAST = CNT_W'(STALL_TIMEOUT - 1);

  state_t                  state_q, state_d;
  bp_req_t                 req_q, req_d;
  logic                    wen_q, wen_d;
  logic                    ren_q, ren_d;
  logic [CNT_W-1:0]        stall_cnt_q, stall_cnt_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                    rsp_error_q, rsp_error_d;
  logic                    rsp_timeout_q, rsp_timeout_d;

  logic                    fifo_push;
  logic                    fifo_pop;
  logic                    fifo_full;
  logic                    fifo_empty;
  bp_req_t                 fifo_wdata;
  bp_req_t                 fifo_rdata;
  logic                    timeout_hit;

  // Request FIFO. req_ready comes only from the registered count.
  assign req_ready  = !fifo_full;
  assign fifo_push  = req_valid && !fifo_full;
  assign fifo_wdata = '{write:  req_write,
                        addr:   BP_ADDR_WIDTH'(req_addr),
                        wdata:  BP_DATA_WIDTH'(req_wdata),
                        strobe: BP_STRB_WIDTH'(req_strobe)};

  bp_req_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .nReset(nReset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign timeout_hit = bp.request_stall && (stall_cnt_q == STALL_LAST);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (nReset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!fifo_empty) state_d = ACCESS;
      ACCESS:  if (!bp.request_stall || timeout_hit) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: FIFO pop plus next values of the bus and response registers.
  always_comb begin
    fifo_pop      = 1'b0;
    req_d         = req_q;
    wen_d         = wen_q;
    ren_d         = ren_q;
    stall_cnt_d   = stall_cnt_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_error_d   = rsp_error_q;
    rsp_timeout_d = rsp_timeout_q;
    case (state_q)
      IDLE: begin
        stall_cnt_d = '0;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          req_d    = fifo_rdata;
          wen_d    = fifo_rdata.write;
          ren_d    = !fifo_rdata.write;
        end
      end
      ACCESS: begin
        if (!bp.request_stall) begin
          wen_d         = 1'b0;
          ren_d         = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = req_q.write ? '0 : bp.rdata;
          rsp_error_d   = bp.error;
          rsp_timeout_d = 1'b0;
        end else if (timeout_hit) begin
          wen_d         = 1'b0;
          ren_d         = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = '0;
          rsp_error_d   = 1'b1;
          rsp_timeout_d = 1'b1;
        end else begin
          stall_cnt_d = stall_cnt_q + 1'b1;
        end
      end
      RESP: begin
        // The payload is held after consumption; only valid drops.
        if (rsp_ready) rsp_valid_d = 1'b0;
      end
      default: begin
        wen_d = 1'b0;
        ren_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (nReset) begin
      req_q         <= '0;
      wen_q         <= 1'b0;
      ren_q         <= 1'b0;
      stall_cnt_q   <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_error_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      req_q         <= req_d;
      wen_q         <= wen_d;
      ren_q         <= ren_d;
      stall_cnt_q   <= stall_cnt_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_error_q   <= rsp_error_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  // Bus outputs come straight from registers.
  assign bp.wen             = wen_q;
  assign bp.ren             = ren_q;
  assign bp.addr            = ADDR_WIDTH'(req_q.addr);
  assign bp.wdata           = DATA_WIDTH'(req_q.wdata);
  assign bp.strobe          = (DATA_WIDTH/8)'(req_q.strobe);
  assign bp.is_burst        = 1'b0;
  assign bp.burst_type      = 2'b00;
  assign bp.burst_length    = 8'd0;
  assign bp.secure_transfer = 1'b0;

  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_error   = rsp_error_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_bp_initiator.sv
module tb_bp_initiator;

  logic        clk = 1'b0;
  logic        nReset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_strobe;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        rsp_timeout;

  logic        periph_stall;
  logic        periph_error;
  logic [31:0] periph_rdata;
  logic        use_addr_data;

  int errors = 0;
  int checks = 0;

  bus_protocol_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  // Peripheral model: either a fixed read value or addr + 0x1000.
  assign bus.rdata         = use_addr_data ? (bus.addr + 32'h1000) : periph_rdata;
  assign bus.error         = periph_error;
  assign bus.request_stall = periph_stall;

  bp_initiator #(
    .ADDR_WIDTH   (32),
    .DATA_WIDTH   (32),
    .FIFO_DEPTH   (4),
    .STALL_TIMEOUT(8)
  ) dut (
    .clk        (clk),
    .nReset     (nReset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_strobe (req_strobe),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_error  (rsp_error),
    .rsp_timeout(rsp_timeout),
    .bp         (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_rsp(input string tag);
    int n = 0;
    while (rsp_valid !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    chk({tag, "_arrive"}, 32'(rsp_valid), 32'd1);
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    logic saw;
    nReset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; req_strobe = '0; rsp_ready = 1'b0;
    periph_stall = 1'b0; periph_error = 1'b0; periph_rdata = '0; use_addr_data = 1'b0;

    // Reset held for two edges
    tick(); tick();
    chk("rst_req_ready",   32'(req_ready),   32'd1);
    chk("rst_rsp_valid",   32'(rsp_valid),   32'd0);
    chk("rst_rsp_rdata",   rsp_rdata,        32'd0);
    chk("rst_rsp_error",   32'(rsp_error),   32'd0);
    chk("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
    chk("rst_wen",         32'(bus.wen),     32'd0);
    chk("rst_ren",         32'(bus.ren),     32'd0);
    chk("rst_addr",        bus.addr,         32'd0);
    chk("rst_wdata",       bus.wdata,        32'd0);
    chk("rst_strobe",      32'(bus.strobe),  32'd0);
    nReset = 1'b0;
    tick();
    $display("txn reset: done");

    // Single write, no stall; rdata from peripheral must be ignored
    periph_rdata = 32'hDEADBEEF;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'd24;
    req_wdata = 32'hCCCCFFFF; req_strobe = 4'hF;
    tick();                                   // edge N: push
    req_valid = 1'b0;
    chk("wr_wen_n", 32'(bus.wen), 32'd0);
    tick();                                   // edge N+1: ACCESS
    chk("wr_wen",    32'(bus.wen),    32'd1);
    chk("wr_ren",    32'(bus.ren),    32'd0);
    chk("wr_addr",   bus.addr,        32'd24);
    chk("wr_wdata",  bus.wdata,       32'hCCCCFFFF);
    chk("wr_strobe", 32'(bus.strobe), 32'hF);
    chk("wr_rspv_n1", 32'(rsp_valid), 32'd0);
    tick();                                   // edge N+2: RESP
    chk("wr_wen_off", 32'(bus.wen),     32'd0);
    chk("wr_rspv",    32'(rsp_valid),   32'd1);
    chk("wr_err",     32'(rsp_error),   32'd0);
    chk("wr_rdata",   rsp_rdata,        32'd0);
    chk("wr_tmo",     32'(rsp_timeout), 32'd0);
    tick();
    chk("wr_hold", 32'(rsp_valid), 32'd1);
    consume();
    chk("wr_rspv_drop", 32'(rsp_valid), 32'd0);
    $display("txn write addr=24 wdata=ccccffff rdata=%h err=%0d", rsp_rdata, rsp_error);

    // Stalled read: 3 stalled edges, then data 0x5A
    periph_stall = 1'b1; periph_rdata = 32'h0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'd20;
    tick();                                   // N: push
    req_valid = 1'b0;
    tick();  chk("rd_ren1", 32'(bus.ren), 32'd1);   // N+1
    chk("rd_addr", bus.addr, 32'd20);
    tick();  chk("rd_ren2", 32'(bus.ren), 32'd1);   // N+2
    tick();  chk("rd_ren3", 32'(bus.ren), 32'd1);   // N+3
    tick();  chk("rd_ren4", 32'(bus.ren), 32'd1);   // N+4
    chk("rd_rspv_stall", 32'(rsp_valid), 32'd0);
    periph_stall = 1'b0; periph_rdata = 32'h0000005A;
    tick();                                   // N+5: completes
    chk("rd_ren_off", 32'(bus.ren),   32'd0);
    chk("rd_rspv",    32'(rsp_valid), 32'd1);
    chk("rd_rdata",   rsp_rdata,      32'h0000005A);
    chk("rd_err",     32'(rsp_error), 32'd0);
    chk("rd_tmo",     32'(rsp_timeout), 32'd0);
    consume();
    $display("txn read addr=20 stalls=3 rdata=%h err=%0d", rsp_rdata, rsp_error);

    // Timeout: stall forever, STALL_TIMEOUT = 8
    periph_stall = 1'b1; periph_rdata = 32'hDEADBEEF;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'd8;
    tick();                                   // N: push
    req_valid = 1'b0;
    tick();                                   // N+1: ACCESS
    repeat (7) tick();                        // stalls 1..7
    chk("to_ren_held", 32'(bus.ren),   32'd1);
    chk("to_rspv_pre", 32'(rsp_valid), 32'd0);
    tick();                                   // 8th stall: abort
    chk("to_rspv",  32'(rsp_valid),   32'd1);
    chk("to_err",   32'(rsp_error),   32'd1);
    chk("to_tmo",   32'(rsp_timeout), 32'd1);
    chk("to_rdata", rsp_rdata,        32'd0);
    chk("to_ren",   32'(bus.ren),     32'd0);
    periph_stall = 1'b0;
    consume();
    $display("txn read addr=8 timeout err=%0d tmo=%0d", rsp_error, rsp_timeout);

    // Write ending with bus error
    periph_error = 1'b1;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h30; req_wdata = 32'h1234; req_strobe = 4'h3;
    tick();
    req_valid = 1'b0;
    wait_rsp("werr");
    chk("werr_err", 32'(rsp_error),   32'd1);
    chk("werr_tmo", 32'(rsp_timeout), 32'd0);
    periph_error = 1'b0;
    consume();
    $display("txn write addr=30 bus error err=%0d tmo=%0d", rsp_error, rsp_timeout);

    // FIFO full / backpressure: 6 offered, 5 accepted
    use_addr_data = 1'b1;
    for (int i = 0; i < 6; i++) begin
      req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h40 + 32'(4 * i);
      chk($sformatf("full_ready%0d", i), 32'(req_ready), (i < 5) ? 32'd1 : 32'd0);
      tick();
    end
    req_valid = 1'b0;
    tick();
    chk("full_hold", 32'(req_ready), 32'd0);
    for (int j = 0; j < 5; j++) begin
      wait_rsp($sformatf("ord%0d", j));
      chk($sformatf("ord%0d_rdata", j), rsp_rdata, 32'h1040 + 32'(4 * j));
      $display("txn read addr=%h rdata=%h", 32'h40 + 32'(4 * j), rsp_rdata);
      consume();
    end
    repeat (4) tick();
    chk("full_no_extra", 32'(rsp_valid), 32'd0);
    chk("full_ready_back", 32'(req_ready), 32'd1);
    use_addr_data = 1'b0;

    // Reset mid-operation with 2 queued
    periph_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h60 + 32'(4 * i);
      tick();
    end
    req_valid = 1'b0;
    chk("mid_ren", 32'(bus.ren), 32'd1);
    nReset = 1'b1;
    tick();
    chk("mid_rst_ren",   32'(bus.ren),   32'd0);
    chk("mid_rst_wen",   32'(bus.wen),   32'd0);
    chk("mid_rst_rspv",  32'(rsp_valid), 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd1);
    nReset = 1'b0; periph_stall = 1'b0;
    saw = 1'b0;
    repeat (6) begin
      tick();
      if (rsp_valid === 1'b1 || bus.ren === 1'b1) saw = 1'b1;
    end
    chk("mid_quiet", 32'(saw), 32'd0);
    $display("txn reset mid-operation: activity=%0d", saw);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bp_initiator.md
# bp_initiator

Bus-master side of `bus_protocol_if`: drives the `protocol` modport toward a peripheral such as `AHBUart`. A local requester pushes read/write commands through a small request FIFO using a valid/ready handshake. The block issues one bus transaction at a time, honours `request_stall`, aborts on stall timeout, and returns read data and error status through a registered response port. It is used as the bench/host-side driver and as the bridge from internal control logic to bus peripherals.

## Interface
- `ADDR_WIDTH`, 32, bus address width
- `DATA_WIDTH`, 32, bus data width; strobe is `DATA_WIDTH/8`
- `FIFO_DEPTH`, 4, request FIFO entries; power of 2, ≥2
- `STALL_TIMEOUT`, 255, maximum consecutive stalled cycles before abort; range 1..65535
- `clk`  in  1  single clock, rising edge
- `nReset`  in  1  reset; synchronous, active-high despite the name
- `req_valid`  in  1  request offered
- `req_ready`  out  1  FIFO can accept (= !full)
- `req_write`  in  1  1 = write, 0 = read
- `req_addr`  in  ADDR_WIDTH  offset address
- `req_wdata`  in  DATA_WIDTH  write data
- `req_strobe`  in  DATA_WIDTH/8  byte enables for writes
- `rsp_valid`  out  1  response held
- `rsp_ready`  in  1  response consumed
- `rsp_rdata`  out  DATA_WIDTH  read data; 0 for writes and for timeouts
- `rsp_error`  out  1  bus `error`, or timeout
- `rsp_timeout`  out  1  response was a stall-timeout abort
- `bp`  modport  `bus_protocol_if.protocol`  drives `wen`, `ren`, `addr`, `wdata`, `strobe`; hint outputs tied 0

## Operation
- **Push:** on an edge where `req_valid && req_ready`, the request is written to the FIFO.
- **FSM states:** IDLE, ACCESS, RESP.
- **IDLE:** if the FIFO is non-empty, pop the head into a request register and go to ACCESS. The stall counter clears.
- **ACCESS:** drive `wen = write`, `ren = !write`, plus `addr`, `wdata` and `strobe` from the request register. All are registered outputs, stable for the whole state.
  - `request_stall == 0` at an edge: capture `rdata` (reads only) and `error` into the response registers, then go to RESP.
  - `request_stall == 1`: increment the stall counter. When the counter equals `STALL_TIMEOUT`, abort: `rsp_error = 1`, `rsp_timeout = 1`, `rsp_rdata = 0`, then go to RESP.
- **RESP:** `rsp_valid = 1`, and the bus is idle (`wen = ren = 0`). On `rsp_ready` go to IDLE. Response fields stay stable while `rsp_valid && !rsp_ready`.
- **Ordering:** strictly one outstanding transaction. Responses come back in request order.
- **Full FIFO:** `req_ready` is 0 and there is no same-cycle bypass. A pop on the same edge frees a slot, visible from the next cycle.
- **Empty FIFO:** no bypass. A request is always stored first.
- **Simultaneous push and pop:** both take effect; the count is unchanged.
- **Pointers:** `$clog2(FIFO_DEPTH)` bits with natural wrap. The count is `$clog2(FIFO_DEPTH)+1` bits.
- **Write-on-error:** a write ending with `error = 1` reports `rsp_error = 1`, `rsp_timeout = 0`.

## Timing
- **Reset values** (checked at the edge with `nReset = 1`):
  - state IDLE; FIFO empty
  - `req_ready = 1`
  - `rsp_valid = 0`, `rsp_rdata = 0`, `rsp_error = 0`, `rsp_timeout = 0`
  - `wen = 0`, `ren = 0`, `addr = 0`, `wdata = 0`, `strobe = 0`
- **Reset mid-operation:** any in-flight transaction is abandoned. The bus deasserts on the reset edge and the FIFO is flushed. No response is produced.
- **Minimum latency:**
  - push at edge N
  - pop to ACCESS at edge N+1, bus driven during cycle N+1
  - with no stall, completion at edge N+2
  - `rsp_valid` high in cycle N+2
- **Back-to-back:** with `rsp_ready` held at 1, each transaction takes 3 cycles (ACCESS, RESP, IDLE).
- **Stall:** the transaction occupies 1 + k cycles in ACCESS for k stalled cycles, with k < `STALL_TIMEOUT`.
- **Timeout:** RESP is entered after exactly `STALL_TIMEOUT` stalled cycles.
- **`req_ready`:** depends only on the registered count, with no combinational path from `req_valid`.

## Structure
- **`bp_initiator_pkg`:**
  - `state_t` enum {IDLE, ACCESS, RESP}
  - `bp_req_t` packed struct {write, addr, wdata, strobe}, parameterised by the package's default widths
- **Sub-module `bp_req_fifo`:** synchronous FIFO of `bp_req_t`.
  - Ports: `push`, `pop`, `full`, `empty`, `wdata`, `rdata`.
  - `rdata` shows the head combinationally.
  - Same reset as the parent.
- **Top:** FSM, request/response registers, stall counter (`$clog2(STALL_TIMEOUT+1)` bits).

## Test plan
- **Reset:** hold `nReset = 1` for 2 cycles, then check every output equals its reset value listed above.
- **Single write:** write `addr = 24`, `wdata = 32'hCCCCFFFF`, `strobe = 4'hF`, no stall.
  - `wen` is high for exactly cycle N+1 with those values.
  - `rsp_valid` rises at N+2 with `rsp_error = 0` and `rsp_rdata = 0`.
- **Stalled read:** read `addr = 20`, peripheral stalls 3 cycles, then returns `rdata = 32'h0000005A`.
  - `ren` is high for 4 cycles.
  - `rsp_rdata = 32'h5A`, `rsp_error = 0`.
- **Timeout:** with `STALL_TIMEOUT = 8`, hold `request_stall = 1` permanently.
  - After 8 stalled cycles: `rsp_error = 1`, `rsp_timeout = 1`, `rsp_rdata = 0`.
  - The bus is idle next cycle.
- **FIFO full/backpressure:** hold `rsp_ready = 0` and push 6 requests (`FIFO_DEPTH = 4`).
  - `req_ready` drops after 4 stored requests plus the one in flight.
  - After `rsp_ready` is released, all 5 accepted responses return in order.
- **Reset mid-operation:** assert `nReset` while in ACCESS with 2 requests queued.
  - The bus deasserts on the reset edge.
  - After release, no `rsp_valid` occurs and the FIFO is empty.
